wb_gpio_irq: RTL and testbench

- Parametrised Wishbone classic slave GPIO; next generation of the fixed 32-bit LED output peripheral.
- Adds per-bit direction, atomic set/clear, synchronised inputs, and rising/falling edge interrupts with W1C status.
- Sits on the SoC wb_intercon as a slave beside RAM; irq_o feeds one bit of the picorv32 irq vector.

---
 rtl/gpio_pkg.sv | 34 +++
 rtl/wb_gpio_irq_if.sv | 21 ++
 rtl/gpio_sync_edge.sv | 43 ++++
 rtl/wb_gpio_irq.sv | 132 +++++++++++++
 tb/tb_wb_gpio_irq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the Wishbone GPIO peripheral with edge interrupts.
// Contents:
//   reg_addr_e          - word offsets decoded from wb adr[4:2]
//   DEFAULT_GPIO_WIDTH  - default number of pins
//   DEFAULT_SYNC_STAGES - default input synchroniser depth
//   ZERO_WORD           - reset value of every bus-visible register except DATA_OUT
//   sel_to_mask()       - expands the 4 Wishbone byte enables to a 32-bit bit mask
package gpio_pkg;

   typedef enum logic [2:0] {
      REG_DATA_OUT = 3'd0,
      REG_SET      = 3'd1,
      REG_CLR      = 3'd2,
      REG_DIR      = 3'd3,
      REG_DATA_IN  = 3'd4,
      REG_RISE_EN  = 3'd5,
      REG_FALL_EN  = 3'd6,
      REG_STATUS   = 3'd7
   } reg_addr_e;

   localparam int          DEFAULT_GPIO_WIDTH  = 32;
   localparam int          DEFAULT_SYNC_STAGES = 2;
   localparam logic [31:0] ZERO_WORD           = 32'h0000_0000;

   function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
      logic [31:0] m;
      m = '0;
      for (int n = 0; n < 4; n++) begin
         m[8*n +: 8] = {8{sel[n]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/wb_gpio_irq_if.sv
// Wishbone classic bus bundle between a master and the GPIO slave.
// Signals:
//   cyc, stb, we  - cycle, strobe, write enable (master -> slave)
//   adr           - byte address (master -> slave)
//   dat_w         - write data (master -> slave)
//   sel           - byte enables (master -> slave)
//   dat_r         - read data (slave -> master)
//   ack           - acknowledge (slave -> master)
interface wb_gpio_irq_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic [31:0] dat_r;
   logic        ack;

   modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack);
   modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack);
endinterface

// File: rtl/gpio_sync_edge.sv
// Input synchroniser plus history flop with edge detection.
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   din          - asynchronous pad inputs
//   sync         - synchronised inputs (last synchroniser stage)
//   rise, fall   - single-cycle pulses, sync vs. the history flop
module gpio_sync_edge #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   // Stage 0 samples the pads; stage SYNC_STAGES-1 is the synchronised value.
   logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_reg;
   logic [WIDTH-1:0]                  hist_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         chain_reg <= '0;
         hist_reg  <= '0;
      end else begin
         chain_reg <= {chain_reg[SYNC_STAGES-2:0], din};
         hist_reg  <= chain_reg[SYNC_STAGES-1];
      end
   end

   assign sync = chain_reg[SYNC_STAGES-1];

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_edge
         assign rise[gi] =  sync[gi] & ~hist_reg[gi];
         assign fall[gi] = ~sync[gi] &  hist_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone classic slave GPIO with per-bit direction, atomic set/clear,
// synchronised inputs and rising/falling edge interrupts (W1C status).
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   wb           - Wishbone slave bundle (registered ack and read data)
//   gpio_i       - asynchronous pad inputs
//   gpio_o       - DATA_OUT register
//   gpio_oe_o    - DIR register, 1 = drive
//   irq_o        - registered level interrupt, high while any STATUS bit is set
module wb_gpio_irq
   import gpio_pkg::*;
#(
   parameter int                    GPIO_WIDTH  = DEFAULT_GPIO_WIDTH,
   parameter int                    SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter logic [GPIO_WIDTH-1:0] OUT_RESET   = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   wb_gpio_irq_if.slave          wb,
   input  logic [GPIO_WIDTH-1:0] gpio_i,
   output logic [GPIO_WIDTH-1:0] gpio_o,
   output logic [GPIO_WIDTH-1:0] gpio_oe_o,
   output logic                  irq_o
);

   logic [GPIO_WIDTH-1:0] data_out_reg, data_out_next;
   logic [GPIO_WIDTH-1:0] dir_reg,      dir_next;
   logic [GPIO_WIDTH-1:0] rise_en_reg,  rise_en_next;
   logic [GPIO_WIDTH-1:0] fall_en_reg,  fall_en_next;
   logic [GPIO_WIDTH-1:0] status_reg,   status_next;
   logic                  ack_reg;
   logic [31:0]           dat_r_reg,    rd_val;
   logic                  irq_reg;

   logic [GPIO_WIDTH-1:0] sync_in, rise, fall, events;
   logic [31:0]           byte_mask;
   logic [GPIO_WIDTH-1:0] wr_bits, wr_mask;
   logic                  req, wr;
   reg_addr_e             reg_sel;
   logic                  unused_adr;

   gpio_sync_edge #(
      .WIDTH       (GPIO_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .din   (gpio_i),
      .sync  (sync_in),
      .rise  (rise),
      .fall  (fall)
   );

   // The ack term keeps a held strobe from being accepted twice.
   assign req       = wb.cyc & wb.stb & ~ack_reg;
   assign wr        = req & wb.we;
   assign reg_sel   = reg_addr_e'(wb.adr[4:2]);
   assign byte_mask = sel_to_mask(wb.sel);
   assign wr_mask   = byte_mask[GPIO_WIDTH-1:0];
   assign wr_bits   = wb.dat_w[GPIO_WIDTH-1:0] & wr_mask;
   assign unused_adr = ^{wb.adr[31:5], wb.adr[1:0]};

   // Output-direction pins are excluded so driven pins never interrupt.
   assign events = ((rise & rise_en_reg) | (fall & fall_en_reg)) & ~dir_reg;

   always_comb begin
      data_out_next = data_out_reg;
      dir_next      = dir_reg;
      rise_en_next  = rise_en_reg;
      fall_en_next  = fall_en_reg;
      status_next   = status_reg;
      if (wr) begin
         case (reg_sel)
            REG_DATA_OUT: data_out_next = (data_out_reg & ~wr_mask) | wr_bits;
            REG_SET:      data_out_next = data_out_reg | wr_bits;
            REG_CLR:      data_out_next = data_out_reg & ~wr_bits;
            REG_DIR:      dir_next      = (dir_reg & ~wr_mask) | wr_bits;
            REG_RISE_EN:  rise_en_next  = (rise_en_reg & ~wr_mask) | wr_bits;
            REG_FALL_EN:  fall_en_next  = (fall_en_reg & ~wr_mask) | wr_bits;
            REG_STATUS:   status_next   = status_reg & ~wr_bits;
            default:      ;
         endcase
      end
      // Applied after the clear so a coincident edge survives a W1C.
      status_next = status_next | events;
   end

   always_comb begin
      rd_val = ZERO_WORD;
      case (reg_sel)
         REG_DATA_OUT: rd_val[GPIO_WIDTH-1:0] = data_out_reg;
         REG_DIR:      rd_val[GPIO_WIDTH-1:0] = dir_reg;
         REG_DATA_IN:  rd_val[GPIO_WIDTH-1:0] = sync_in;
         REG_RISE_EN:  rd_val[GPIO_WIDTH-1:0] = rise_en_reg;
         REG_FALL_EN:  rd_val[GPIO_WIDTH-1:0] = fall_en_reg;
         REG_STATUS:   rd_val[GPIO_WIDTH-1:0] = status_reg;
         default:      rd_val = ZERO_WORD;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_out_reg <= OUT_RESET;
         dir_reg      <= '0;
         rise_en_reg  <= '0;
         fall_en_reg  <= '0;
         status_reg   <= '0;
         ack_reg      <= 1'b0;
         dat_r_reg    <= ZERO_WORD;
         irq_reg      <= 1'b0;
      end else begin
         data_out_reg <= data_out_next;
         dir_reg      <= dir_next;
         rise_en_reg  <= rise_en_next;
         fall_en_reg  <= fall_en_next;
         status_reg   <= status_next;
         ack_reg      <= req;
         irq_reg      <= |status_reg;
         // Read data is captured only on an accepted request and held otherwise.
         if (req) begin
            dat_r_reg <= rd_val;
         end
      end
   end

   assign wb.ack    = ack_reg;
   assign wb.dat_r  = dat_r_reg;
   assign gpio_o    = data_out_reg;
   assign gpio_oe_o = dir_reg;
   assign irq_o     = irq_reg;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed bench for wb_gpio_irq: register reset values, byte-enabled
// writes, set/clear, edge interrupts, W1C race and asynchronous reset.
module tb_wb_gpio_irq;
   import gpio_pkg::*;

   localparam logic [31:0] OUT_RST = 32'h0000_005A;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] gpio_i = '0;
   logic [31:0] gpio_o, gpio_oe_o;
   logic        irq_o;
   logic [31:0] rd;

   int checks   = 0;
   int failures = 0;

   wb_gpio_irq_if bus ();

   wb_gpio_irq #(
      .GPIO_WIDTH  (32),
      .SYNC_STAGES (2),
      .OUT_RESET   (OUT_RST)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wb        (bus.slave),
      .gpio_i    (gpio_i),
      .gpio_o    (gpio_o),
      .gpio_oe_o (gpio_oe_o),
      .irq_o     (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%08h", tag, got);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the ack edge.
   task automatic wb_xfer(input logic we, input logic [2:0] idx, input logic [31:0] wdat,
                          input logic [3:0] sel, output logic [31:0] rdat);
      int cyc;
      if (bus.ack) begin
         @(posedge clk_i); #1;
      end
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we;
      bus.adr = {27'd0, idx, 2'b00}; bus.dat_w = wdat; bus.sel = sel;
      cyc = 0;
      do begin
         @(posedge clk_i); #1;
         cyc++;
      end while (!bus.ack && cyc < 8);
      check($sformatf("ack_latency_%s_%0d", we ? "wr" : "rd", idx), cyc, 1);
      rdat = bus.dat_r;
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
   endtask

   task automatic wb_write(input logic [2:0] idx, input logic [31:0] wdat, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_xfer(1'b1, idx, wdat, sel, dummy);
   endtask

   task automatic wb_read(input logic [2:0] idx, output logic [31:0] rdat);
      wb_xfer(1'b0, idx, 32'h0, 4'hF, rdat);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [31:0] exp_rst [8];
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
      bus.adr = '0; bus.dat_w = '0; bus.sel = '0;
      exp_rst = '{OUT_RST, 0, 0, 0, 0, 0, 0, 0};

      cycles(3);
      check("rst_ack", {31'd0, bus.ack}, 0);
      check("rst_irq", {31'd0, irq_o}, 0);
      rst_i = 1'b0;
      cycles(1);

      // Reset values of all eight registers
      for (int i = 0; i < 8; i++) begin
         wb_read(3'(i), rd);
         check($sformatf("rst_reg%0d", i), rd, exp_rst[i]);
      end
      check("rst_gpio_o", gpio_o, OUT_RST);
      check("rst_gpio_oe", gpio_oe_o, 0);

      // Byte-enabled write, set, clear
      wb_write(3'(REG_DATA_OUT), 32'h0000_00F0, 4'b0001);
      check("dout_wr", gpio_o, 32'h0000_00F0);
      wb_write(3'(REG_SET), 32'h0000_000F, 4'b0001);
      check("dout_set", gpio_o, 32'h0000_00FF);
      wb_write(3'(REG_CLR), 32'h0000_0030, 4'b0001);
      check("dout_clr", gpio_o, 32'h0000_00CF);
      wb_read(3'(REG_SET), rd);
      check("set_reads0", rd, 0);
      wb_write(3'(REG_DATA_OUT), 32'hFFFF_FFFF, 4'b0010);
      check("dout_sel1", gpio_o, 32'h0000_FFCF);
      wb_read(3'(REG_DATA_OUT), rd);
      check("dout_rd", rd, 32'h0000_FFCF);
      wb_write(3'(REG_DATA_IN), 32'hFFFF_FFFF, 4'hF);
      wb_read(3'(REG_DATA_IN), rd);
      check("din_ro", rd, 0);

      // Rising edge on bit 0: change before edge k, STATUS at k+2, irq at k+3
      wb_write(3'(REG_DIR), 32'h0, 4'hF);
      wb_write(3'(REG_RISE_EN), 32'h1, 4'hF);
      cycles(1);
      gpio_i[0] = 1'b1;
      cycles(2);
      check("irq_k1", {31'd0, irq_o}, 0);
      cycles(1);
      check("irq_k2", {31'd0, irq_o}, 0);
      cycles(1);
      check("irq_k3", {31'd0, irq_o}, 1);
      wb_read(3'(REG_STATUS), rd);
      check("status_rise0", rd, 32'h1);
      wb_read(3'(REG_DATA_IN), rd);
      check("din_bit0", rd, 32'h1);
      wb_write(3'(REG_STATUS), 32'h1, 4'hF);
      check("irq_after_w1c", {31'd0, irq_o}, 1);
      cycles(1);
      check("irq_drop", {31'd0, irq_o}, 0);
      wb_read(3'(REG_STATUS), rd);
      check("status_w1c", rd, 0);

      // Output-direction pin never interrupts
      wb_write(3'(REG_FALL_EN), 32'h2, 4'hF);
      wb_write(3'(REG_DIR), 32'h2, 4'hF);
      check("oe_bit1", gpio_oe_o, 32'h2);
      gpio_i[1] = 1'b1; cycles(4);
      gpio_i[1] = 1'b0; cycles(4);
      wb_read(3'(REG_STATUS), rd);
      check("status_dir_out", rd, 0);
      wb_write(3'(REG_DIR), 32'h0, 4'hF);
      gpio_i[1] = 1'b1; cycles(4);
      wb_read(3'(REG_STATUS), rd);
      check("status_rise_noen", rd, 0);
      gpio_i[1] = 1'b0; cycles(4);
      wb_read(3'(REG_STATUS), rd);
      check("status_fall1", rd, 32'h2);
      wb_write(3'(REG_DIR), 32'h2, 4'hF);
      wb_read(3'(REG_STATUS), rd);
      check("status_dir_keep", rd, 32'h2);
      wb_write(3'(REG_DIR), 32'h0, 4'hF);
      wb_write(3'(REG_STATUS), 32'h2, 4'hF);
      cycles(2);
      check("irq_clear2", {31'd0, irq_o}, 0);

      // Enabling while already high creates no event
      gpio_i[2] = 1'b1; cycles(4);
      wb_write(3'(REG_RISE_EN), 32'h5, 4'hF);
      cycles(4);
      wb_read(3'(REG_STATUS), rd);
      check("status_en_high", rd, 0);

      // Edge on bit 3 coinciding with W1C of bit 3
      wb_write(3'(REG_RISE_EN), 32'hD, 4'hF);
      gpio_i[3] = 1'b1; cycles(4);
      wb_read(3'(REG_STATUS), rd);
      check("status_rise3", rd, 32'h8);
      gpio_i[3] = 1'b0; cycles(4);
      check("irq_pre_race", {31'd0, irq_o}, 1);
      gpio_i[3] = 1'b1;
      cycles(2);
      wb_write(3'(REG_STATUS), 32'h8, 4'hF);
      check("irq_race0", {31'd0, irq_o}, 1);
      cycles(1);
      check("irq_race1", {31'd0, irq_o}, 1);
      cycles(1);
      check("irq_race2", {31'd0, irq_o}, 1);
      wb_read(3'(REG_STATUS), rd);
      check("status_race", rd, 32'h8);

      // Asynchronous reset while a write strobe is held
      cycles(1);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
      bus.adr = {27'd0, 3'(REG_DATA_OUT), 2'b00}; bus.dat_w = 32'h1234_5678; bus.sel = 4'hF;
      @(posedge clk_i); #1;
      check("mid_ack_high", {31'd0, bus.ack}, 1);
      #1 rst_i = 1'b1;
      #1;
      check("mid_ack_async", {31'd0, bus.ack}, 0);
      check("mid_gpio_o", gpio_o, OUT_RST);
      check("mid_oe", gpio_oe_o, 0);
      check("mid_irq", {31'd0, irq_o}, 0);
      @(posedge clk_i); #1;
      check("mid_ack_held", {31'd0, bus.ack}, 0);
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
      rst_i = 1'b0;
      cycles(1);
      wb_read(3'(REG_DATA_OUT), rd);
      check("post_rst_dout", rd, OUT_RST);
      wb_read(3'(REG_STATUS), rd);
      check("post_rst_status", rd, 0);
      wb_read(3'(REG_RISE_EN), rd);
      check("post_rst_rise_en", rd, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
